// File: rtl/rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_arbiter
// Purpose  : Shares one synchronous ROM port between a CPU fetch requester and
//            a debug/loader requester. Responses are routed back by port tag.
// Revision : 1.0  initial release
// ============================================================================
module rom_fetch_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_RUN    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_clken,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam logic [3:0] c_max_run = MAX_RUN[3:0];

  logic [3:0]            r_run;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [RD_LATENCY-1:0] r_vld;
  logic [RD_LATENCY-1:0] r_tag;

  logic                  w_grant_f;
  logic                  w_grant_d;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic                  w_out_vld;
  logic                  w_out_tag;

  // Fetch wins contention until it has taken MAX_RUN grants in a row.
  always_comb begin
    w_grant_f = 1'b0;
    w_grant_d = 1'b0;
    if (!reset) begin
      if (d_req && (!f_req || r_run == c_max_run)) begin
        w_grant_d = 1'b1;
      end else if (f_req) begin
        w_grant_f = 1'b1;
      end
    end
  end

  assign w_issue      = w_grant_f | w_grant_d;
  assign w_issue_addr = w_grant_d ? d_addr : f_addr;

  assign f_gnt       = w_grant_f;
  assign d_gnt       = w_grant_d;
  assign rom_clken   = w_issue;
  assign rom_address = w_issue ? w_issue_addr : r_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_issue) begin
      r_addr <= w_issue_addr;
    end
  end

  // Counts fetch grants only while debug is actually waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run <= 4'd0;
    end else if (!d_req || w_grant_d) begin
      r_run <= 4'd0;
    end else if (w_grant_f && r_run != c_max_run) begin
      r_run <= r_run + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_tag[0] <= w_grant_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_out_vld = r_vld[RD_LATENCY-1];
  assign w_out_tag = r_tag[RD_LATENCY-1];

  assign f_rvalid = w_out_vld & ~w_out_tag;
  assign d_rvalid = w_out_vld &  w_out_tag;
  assign f_rdata  = f_rvalid ? rom_q : '0;
  assign d_rdata  = d_rvalid ? rom_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_arbiter
// Purpose  : Scoreboard bench for rom_fetch_arbiter with a behavioural ROM.
// Revision : 1.0  initial release
// ============================================================================
module tb_rom_fetch_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int MR  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          f_req = 1'b0;
  logic          d_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [AW-1:0] d_addr = '0;
  logic          f_gnt, d_gnt, f_rvalid, d_rvalid, rom_clken;
  logic [DW-1:0] f_rdata, d_rdata, rom_q;
  logic [AW-1:0] rom_address;

  rom_fetch_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .MAX_RUN(MR)
  ) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rom_address(rom_address), .rom_clken(rom_clken), .rom_q(rom_q)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a, ~a, 12'hA5C};
  endfunction

  // Synchronous ROM: enabled address register followed by LAT-1 data stages.
  logic [AW-1:0] rom_areg = '0;
  logic [DW-1:0] qd [LAT];
  always @(posedge clock) begin
    if (rom_clken) rom_areg <= rom_address;
    for (int i = LAT - 1; i >= 1; i--) qd[i] <= (i == 1) ? rom_word(rom_areg) : qd[i-1];
  end
  assign rom_q = (LAT == 1) ? rom_word(rom_areg) : qd[LAT-1];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } exp_t;

  exp_t          sbq[$];
  int            run_m  = 0;
  logic [AW-1:0] last_m = '0;
  logic          ef, ed;

  // Reference arbiter: decides the grant from the request rules, pushes responses.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_f_gnt", f_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_clken", rom_clken, 0);
      chk("rst_rom_address", rom_address, 0);
      run_m  = 0;
      last_m = '0;
      sbq.delete();
    end else begin
      ef = 1'b0;
      ed = 1'b0;
      if (f_req && d_req) begin
        if (run_m == MR) ed = 1'b1; else ef = 1'b1;
      end else if (f_req) begin
        ef = 1'b1;
      end else if (d_req) begin
        ed = 1'b1;
      end
      chk("f_gnt", f_gnt, ef);
      chk("d_gnt", d_gnt, ed);
      chk("rom_clken", rom_clken, ef | ed);
      if (ef) begin
        chk("rom_address_f", rom_address, f_addr);
        last_m = f_addr;
        sbq.push_back('{port: 1'b0, data: rom_word(f_addr), due: cyc + LAT});
      end else if (ed) begin
        chk("rom_address_d", rom_address, d_addr);
        last_m = d_addr;
        sbq.push_back('{port: 1'b1, data: rom_word(d_addr), due: cyc + LAT});
      end else begin
        chk("rom_address_hold", rom_address, last_m);
      end
      if (!d_req || ed) run_m = 0;
      else if (ef && run_m < MR) run_m = run_m + 1;
    end
  end

  // Response monitor.
  exp_t e;
  always @(negedge clock) begin
    chk("rvalid_exclusive", f_rvalid & d_rvalid, 0);
    if (!f_rvalid) chk("f_rdata_zero", f_rdata, 0);
    if (!d_rvalid) chk("d_rdata_zero", d_rdata, 0);
    if (f_rvalid || d_rvalid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rvalid", f_rvalid | d_rvalid, 0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_port", d_rvalid, e.port);
        chk("rsp_data", d_rvalid ? d_rdata : f_rdata, e.data);
        chk("rsp_cycle", cyc, e.due);
      end
    end else if (!reset && sbq.size() > 0 && sbq[0].due < cyc) begin
      chk("missing_rvalid", f_rvalid | d_rvalid, 1);
      void'(sbq.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle and checks the grant against a fixed expected pattern.
  task automatic drive_seq(input logic fr, input logic dr, input logic exp_d, input string name);
    f_req  = fr;
    d_req  = dr;
    f_addr = AW'($urandom);
    d_addr = AW'($urandom);
    #1;
    chk(name, {f_gnt, d_gnt}, {~exp_d & fr, exp_d});
    step();
  endtask

  logic fg, dg;

  initial begin
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Single fetch
    f_req = 1'b1; f_addr = 10'h010; step();
    f_req = 1'b0; repeat (4) step();

    // Contention: F,F,F,F,D repeated
    for (int i = 0; i < 10; i++) drive_seq(1'b1, 1'b1, (i % 5) == 4, "contention_seq");
    f_req = 1'b0; d_req = 1'b0; repeat (3) step();

    // Debug only, address wrap
    d_req = 1'b1; d_addr = 10'h3FE; step();
    d_addr = 10'h3FF; step();
    d_addr = 10'h000; step();
    d_req = 1'b0; repeat (4) step();

    // Idle hold after access to 0x055
    f_req = 1'b1; f_addr = 10'h055; step();
    f_req = 1'b0; repeat (6) step();

    // d_req dropping clears the run counter
    for (int i = 0; i < 3; i++) drive_seq(1'b1, 1'b1, 1'b0, "drop_seq");
    drive_seq(1'b1, 1'b0, 1'b0, "drop_seq");
    for (int i = 0; i < 5; i++) drive_seq(1'b1, 1'b1, i == 4, "drop_seq");
    f_req = 1'b0; d_req = 1'b0; repeat (3) step();

    // Reset mid-flight
    f_req = 1'b1; f_addr = 10'h020; step();
    f_req = 1'b0; reset = 1'b1;
    #1;
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) drive_seq(1'b1, 1'b1, i == 4, "post_reset_seq");
    f_req = 1'b0; d_req = 1'b0; repeat (4) step();

    // Randomized traffic; requests hold until granted
    fg = 1'b0; dg = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!f_req || fg) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = AW'($urandom);
      end
      if (!d_req || dg) begin
        d_req  = ($urandom_range(0, 1) != 0);
        d_addr = AW'($urandom);
      end
      #1;
      fg = f_gnt;
      dg = d_gnt;
      step();
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 3) step();
    chk("sb_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rom_fetch_arbiter.md
ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, ROM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM word width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, cycles from ROM issue to valid q; legal range 1..4.
REQ-004 SHALL have parameter MAX_RUN, default 4, maximum consecutive fetch grants while debug waits; legal range 1..15.
REQ-005 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port f_req  in  1  CPU fetch request, held until granted.
REQ-008 SHALL have port f_addr  in  ADDR_WIDTH  fetch word address, stable while f_req high.
REQ-009 SHALL have port f_gnt  out  1  fetch accepted this cycle.
REQ-010 SHALL have port f_rvalid  out  1  f_rdata valid this cycle.
REQ-011 SHALL have port f_rdata  out  DATA_WIDTH  fetch read data.
REQ-012 SHALL have ports d_req, d_addr, d_gnt, d_rvalid, d_rdata, identical to the f_* ports, for the debug/loader requester.
REQ-013 SHALL have port rom_address  out  ADDR_WIDTH  address to ROM.
REQ-014 SHALL have port rom_clken  out  1  ROM address-register enable.
REQ-015 SHALL have port rom_q  in  DATA_WIDTH  ROM data.

Function
REQ-016 SHALL issue at most one ROM access per cycle; issue = rom_clken high with rom_address = granted requester's address, combinationally in the grant cycle.
REQ-017 SHALL assert exactly one of f_gnt/d_gnt in an issue cycle, and neither otherwise; rom_clken = f_gnt OR d_gnt.
REQ-018 SHALL hold rom_address at the last issued value when no issue occurs (rom_clken low).
REQ-019 SHALL grant the only requesting port when one of f_req/d_req is high.
REQ-020 SHALL, with both requesting, grant fetch unless run counter equals MAX_RUN, in which case grant debug.
REQ-021 SHALL keep a run counter: increment (saturating at MAX_RUN) on a fetch grant while d_req high; clear on any debug grant or on any cycle with d_req low.
REQ-022 SHALL accept back-to-back requests: a port held high is granted on consecutive cycles subject to REQ-020.
REQ-023 SHALL carry a 1-bit port tag plus valid bit through a RD_LATENCY-deep pipeline; after RD_LATENCY cycles the tagged port's rvalid SHALL pulse for one cycle with rdata = rom_q.
REQ-024 SHALL return responses in issue order; never assert f_rvalid and d_rvalid in the same cycle.
REQ-025 SHALL drive f_rdata/d_rdata to rom_q only when the matching rvalid is high, else zero.
REQ-026 SHALL not stall: requesters accept rvalid unconditionally; no back-pressure input exists.
REQ-027 SHALL treat f_req and d_req both low as idle: no issue, pipeline drains normally.

Reset
REQ-028 SHALL, on reset high, asynchronously clear run counter, pipeline valid bits, tags and rom_address register to zero.
REQ-029 SHALL hold f_gnt, d_gnt, rom_clken, f_rvalid, d_rvalid low and rdata outputs zero while reset is high.
REQ-030 SHALL discard in-flight accesses when reset asserts mid-operation; no rvalid for them after release.
REQ-031 SHALL resume arbitration on the first rising edge after reset deasserts, run counter zero.

Verification
REQ-032 Fetch only: f_req=1, f_addr=0x010 for one cycle -> f_gnt=1, rom_clken=1, rom_address=0x010 that cycle; f_rvalid=1, f_rdata=rom_q exactly RD_LATENCY=1 cycle later; d_* stay 0.
REQ-033 Contention, MAX_RUN=4: f_req and d_req held high 10 cycles -> grant sequence F,F,F,F,D,F,F,F,F,D; responses in the same order one cycle later.
REQ-034 Debug only with RD_LATENCY=3: d_req high addresses 0x3FE,0x3FF,0x000 on consecutive cycles -> three d_rvalid pulses on cycles 3,4,5 after first issue, data in order, address wrap accepted.
REQ-035 Idle hold: no requests for 5 cycles after an access to 0x055 -> rom_clken=0, rom_address=0x055 throughout, no rvalid.
REQ-036 Reset mid-flight, RD_LATENCY=2: issue fetch to 0x020, assert reset next cycle -> no f_rvalid ever for it; all outputs 0 during reset; first grant after release has run counter 0.
REQ-037 d_req dropping: both requesting 3 cycles, d_req low 1 cycle, both again -> counter cleared, four further fetch grants before debug is granted.
